// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
//
// Owns the D-bit PC and a four-state control FSM (IDLE/RUN/REDIRECT/DONE).
// Branch targets come from an external combinational LUT. The LUT index is
// driven straight from br_sel_i, and the returned value is consumed in the
// same cycle.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous, active-high reset
//   start_i        begin/restart execution (honoured in IDLE or DONE)
//   stall_i        hold PC/icount/state this cycle (RUN only)
//   halt_req_i     stop after the current fetch (RUN only)
//   br_en_i        current instruction is a branch
//   br_cond_i      branch condition from ALU
//   br_abs_i       1 = LUT value is absolute target, 0 = signed offset
//   br_sel_i       LUT entry select
//   lut_target_i   LUT return value (target or offset)
//   lut_addr_o     LUT index (= br_sel_i)
//   pc_o           current fetch address
//   fetch_valid_o  pc_o is a valid fetch (RUN)
//   flush_o        squash younger instruction (REDIRECT)
//   done_o         program halted (DONE)
//   icount_o       saturating retired-fetch counter
module pc_sequencer #(
  parameter int              D        = 12,
  parameter logic [D-1:0]    START_PC = '0,
  parameter int              CW       = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          stall_i,
  input  logic          halt_req_i,
  input  logic          br_en_i,
  input  logic          br_cond_i,
  input  logic          br_abs_i,
  input  logic [2:0]    br_sel_i,
  input  logic [D-1:0]  lut_target_i,
  output logic [2:0]    lut_addr_o,
  output logic [D-1:0]  pc_o,
  output logic          fetch_valid_o,
  output logic          flush_o,
  output logic          done_o,
  output logic [CW-1:0] icount_o
);

  // One-hot encoding. Any other pattern is illegal and falls back to IDLE.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_RUN   = 4'b0010,
    S_REDIR = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] icount_q, icount_d;

  logic          taken;
  logic [D-1:0]  pc_seq, pc_br;
  logic [CW-1:0] icount_inc;

  assign lut_addr_o = br_sel_i;
  assign taken      = br_en_i & br_cond_i;

  // A D-bit add discards the carry, so the relative offset behaves as two's
  // complement, and 2^D-1 wraps to 0 on the sequential path.
  assign pc_seq     = pc_q + D'(1);
  assign pc_br      = br_abs_i ? lut_target_i : (pc_q + lut_target_i);
  assign icount_inc = (&icount_q) ? icount_q : (icount_q + CW'(1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          pc_d    = START_PC;
        end
      end
      S_RUN: begin
        if (!stall_i) begin
          icount_d = icount_inc;
          if (halt_req_i) begin
            state_d = S_DONE;
          end else if (taken) begin
            state_d = S_REDIR;
            pc_d    = pc_br;
          end else begin
            pc_d    = pc_seq;
          end
        end
      end
      // The bubble lasts exactly one cycle, whatever the inputs do.
      S_REDIR: state_d = S_RUN;
      S_DONE: begin
        if (start_i) begin
          state_d  = S_RUN;
          pc_d     = START_PC;
          icount_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end

  assign pc_o          = pc_q;
  assign icount_o      = icount_q;
  assign fetch_valid_o = (state_q == S_RUN);
  assign flush_o       = (state_q == S_REDIR);
  assign done_o        = (state_q == S_DONE);

endmodule
